mem_responder: RTL and testbench

Word-addressed data-memory responder for the 12-bit ARM processor's data port: the slave end of the load/store interface the CPU drives with MemoryWrite, ALUResult (address) and WriteData, returning ReadData. It adds a request/ready handshake and a programmable wait-state counter, so the multicycle CPU variant can be tested against slow memory. It sits between the CPU core and the on-chip data RAM.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_word_array.sv | 23 ++
 rtl/mem_responder.sv | 108 ++++++++++
 tb/tb_mem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM state codes and the latched request payload for mem_responder.
package mem_responder_pkg;

  localparam int unsigned WORD_W = 12;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 12-bit word storage: synchronous write, combinational read. Contents are never reset.
module mem_word_array
  import mem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder with request/ready handshake and fixed wait states.
// Optional out-of-range checking on upper address bits: MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemoryRequest,
  input  logic              MemoryWrite,
  input  logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              MemoryReady,
  output logic              MemoryError
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  mem_req_t          lat_q, lat_nxt, cur_c;
  logic              enter_resp_c;
  logic              in_range_c;
  logic              we_c;
  logic [AW-1:0]     idx_c;
  logic [WORD_W-1:0] arr_rdata_c;
  logic [WORD_W-1:0] rdata_nxt;

  // In IDLE the live inputs are the transaction; afterwards only the latched copy counts.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_nxt      = lat_q;
    cur_c        = lat_q;
    case (state)
      ST_IDLE: begin
        cur_c = '{write: MemoryWrite, addr: Address, wdata: WriteData};
        if (MemoryRequest) begin
          lat_nxt = cur_c;
          if (WAIT_CYCLES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_RESP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    enter_resp_c = (state_nxt == ST_RESP);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    in_range_c   = ((cur_c.addr >> AW) == '0);
`else
    in_range_c   = 1'b1;
`endif
    idx_c        = AW'(cur_c.addr);
    we_c         = enter_resp_c & cur_c.write & in_range_c;
    rdata_nxt    = ReadData;
    if (enter_resp_c && !cur_c.write) rdata_nxt = in_range_c ? arr_rdata_c : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_q       <= '0;
      ReadData    <= '0;
      MemoryReady <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      lat_q       <= lat_nxt;
      ReadData    <= rdata_nxt;
      MemoryReady <= enter_resp_c;
    end
  end

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= enter_resp_c & ~in_range_c;
  end

  assign MemoryError = err_q;
`else
  assign MemoryError = 1'b0;
`endif

  mem_word_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we      (we_c),
    .addr    (idx_c),
    .wdata   (cur_c.wdata),
    .rdata_c (arr_rdata_c)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: two instances (2 wait states / 256 words, 0 wait states / 16 words)
// checked against an array-based memory model and a latency rule.
module tb_mem_responder;

  localparam int unsigned DEP0 = 256, WT0 = 2;
  localparam int unsigned DEP1 = 16,  WT1 = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req  [2];
  logic        wr   [2];
  logic [11:0] addr [2];
  logic [11:0] wdat [2];
  logic [11:0] rdat [2];
  logic        rdy  [2];
  logic        err  [2];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEP0), .WAIT_CYCLES(WT0)) u_dut0 (
    .clk(clk), .reset(reset), .MemoryRequest(req[0]), .MemoryWrite(wr[0]),
    .Address(addr[0]), .WriteData(wdat[0]), .ReadData(rdat[0]),
    .MemoryReady(rdy[0]), .MemoryError(err[0])
  );

  mem_responder #(.DEPTH(DEP1), .WAIT_CYCLES(WT1)) u_dut1 (
    .clk(clk), .reset(reset), .MemoryRequest(req[1]), .MemoryWrite(wr[1]),
    .Address(addr[1]), .WriteData(wdat[1]), .ReadData(rdat[1]),
    .MemoryReady(rdy[1]), .MemoryError(err[1])
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] mm      [2][256];
  bit          kn      [2][256];
  logic [11:0] last_rd [2];
  bit          rd_kn   [2];

  function automatic int dep(input int d);
    return (d == 0) ? int'(DEP0) : int'(DEP1);
  endfunction

  function automatic int wt(input int d);
    return (d == 0) ? int'(WT0) : int'(WT1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One transaction, driven at a negedge. from_resp: the DUT is currently in its response cycle.
  task automatic txn(input int d, input bit w, input logic [11:0] a, input logic [11:0] wd,
                     input bit from_resp, input bit scramble);
    int n;
    bit seen;
    int idx;
    bit exp_err;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdat[d] = wd;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[d] === 1'b1) seen = 1;
      else if (scramble && n >= (from_resp ? 2 : 1)) begin
        addr[d] = a ^ 12'h010;
        wdat[d] = 12'($urandom);
        wr[d]   = ~w;
      end
    end
    check($sformatf("latency d%0d a=%03h", d, a), n, wt(d) + 1 + int'(from_resp));

    idx = int'(a) % dep(d);
    exp_err = 0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    if (int'(a) >= dep(d)) exp_err = 1;
`endif
    if (exp_err) begin
      if (!w) begin last_rd[d] = '0; rd_kn[d] = 1; end
    end else if (w) begin
      mm[d][idx] = wd; kn[d][idx] = 1;
    end else begin
      last_rd[d] = mm[d][idx]; rd_kn[d] = kn[d][idx];
    end
    check($sformatf("error d%0d a=%03h", d, a), err[d], exp_err);
    if (rd_kn[d]) check($sformatf("rdata d%0d a=%03h w=%0b", d, a, w), rdat[d], last_rd[d]);
  endtask

  task automatic idle(input int d);
    req[d] = 1'b0;
    @(negedge clk);
    check($sformatf("ready_low d%0d", d), rdy[d], 1'b0);
  endtask

  initial begin
    bit prev_resp, b2b, w;
    logic [11:0] a;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; wr[d] = 0; addr[d] = '0; wdat[d] = '0;
      last_rd[d] = '0; rd_kn[d] = 1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready d%0d", d), rdy[d], 1'b0);
      check($sformatf("rst_rdata d%0d", d), rdat[d], 12'h000);
      check($sformatf("rst_error d%0d", d), err[d], 1'b0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Basic store/load with wait states
    txn(0, 1, 12'h010, 12'h5A5, 0, 0); idle(0);
    txn(0, 0, 12'h010, 12'h000, 0, 0); idle(0);

    // Inputs disturbed during WAIT must not be resampled
    txn(0, 1, 12'h030, 12'h333, 0, 0); idle(0);
    txn(0, 1, 12'h020, 12'h9C3, 0, 1); idle(0);
    txn(0, 0, 12'h030, 12'h000, 0, 0); idle(0);
    txn(0, 0, 12'h020, 12'h000, 0, 1); idle(0);

    // Upper address bits: aliasing or range error depending on build
    txn(0, 1, 12'h005, 12'h0AA, 0, 0); idle(0);
    txn(0, 1, 12'h105, 12'h111, 0, 0); idle(0);
    txn(0, 0, 12'h005, 12'h000, 0, 0); idle(0);
    txn(0, 0, 12'h1FF, 12'h000, 0, 0); idle(0);

    // Reset in the middle of a store's WAIT phase abandons it
    txn(0, 1, 12'h005, 12'h123, 0, 0); idle(0);
    txn(0, 0, 12'h005, 12'h000, 0, 0); idle(0);
    req[0] = 1; wr[0] = 1; addr[0] = 12'h005; wdat[0] = 12'hABC;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready", rdy[0], 1'b0);
    check("midrst_rdata", rdat[0], 12'h000);
    check("midrst_error", err[0], 1'b0);
    for (int d = 0; d < 2; d++) begin last_rd[d] = '0; rd_kn[d] = 1; end
    req[0] = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    txn(0, 0, 12'h005, 12'h000, 0, 0); idle(0);

    // Zero wait states, request held high, alternating store/load
    txn(1, 1, 12'h003, 12'h456, 0, 0);
    for (int i = 0; i < 8; i++) begin
      a = 12'(i * 5);
      txn(1, 0, 12'h003 + 12'(i), 12'h000, 1, 0);
      txn(1, 1, 12'h004 + 12'(i), 12'h700 + a, 1, 0);
    end
    txn(1, 0, 12'h00B, 12'h000, 1, 0);
    idle(1);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      prev_resp = 0;
      repeat (120) begin
        w = 1'($urandom);
        if ($urandom_range(0, 3) == 0) a = 12'($urandom);
        else a = 12'($urandom_range(0, dep(d) - 1));
        b2b = prev_resp && 1'($urandom);
        if (prev_resp && !b2b) idle(d);
        txn(d, w, a, 12'($urandom), b2b, ($urandom_range(0, 4) == 0));
        prev_resp = 1;
      end
      idle(d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
